// File: rtl/softmax_backward.sv
`default_nettype none
// ============================================================================
// Module   : softmax_backward
// Brief    : Streaming softmax gradient, dx_i = y_i * (dy_i - sum_j y_j*dy_j),
//            buffered per vector and drained under valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module softmax_backward #(
    parameter int VEC_LEN   = 16,
    parameter int FRAC_BITS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    output logic        ready_in,
    input  logic [31:0] y_in,
    input  logic [31:0] dy_in,
    output logic        valid_out,
    input  logic        ready_out,
    output logic [31:0] output_data,
    output logic        last_out
);

    localparam int IDX_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(VEC_LEN - 1);
    localparam logic [0:0]       c_ST_LOAD  = 1'b0;
    localparam logic [0:0]       c_ST_DRAIN = 1'b1;

    localparam logic signed [47:0] c_ACC_MAX = 48'sd2147483647;
    localparam logic signed [47:0] c_ACC_MIN = -48'sd2147483648;
    localparam logic signed [64:0] c_OUT_MAX = 65'sd2147483647;
    localparam logic signed [64:0] c_OUT_MIN = -65'sd2147483648;

    logic [0:0]          r_state;
    logic [IDX_W-1:0]    r_wr_idx;
    logic [IDX_W-1:0]    r_rd_idx;
    logic signed [47:0]  r_acc;
    logic [31:0]         r_y_buf  [VEC_LEN];
    logic [31:0]         r_dy_buf [VEC_LEN];

    logic                w_in_hs;
    logic                w_out_hs;
    logic                w_out_load;
    logic signed [63:0]  w_prod_in;
    logic signed [47:0]  w_term;
    logic signed [31:0]  w_dot;
    logic [31:0]         w_y_rd;
    logic [31:0]         w_dy_rd;
    logic signed [32:0]  w_diff;
    logic signed [64:0]  w_prod_out;
    logic signed [64:0]  w_prod_out_sh;
    logic [31:0]         w_dx;

    assign ready_in   = (r_state == c_ST_LOAD);
    assign w_in_hs    = valid_in & ready_in;
    assign w_out_hs   = valid_out & ready_out;
    // last_out stays high until its handshake, so it doubles as "all issued"
    assign w_out_load = (r_state == c_ST_DRAIN) & (~valid_out | ready_out) & ~last_out;

    assign w_prod_in = $signed({{32{y_in[31]}}, y_in}) * $signed({{32{dy_in[31]}}, dy_in});
    assign w_term    = 48'(w_prod_in >>> FRAC_BITS);

    always_comb begin
        w_dot = r_acc[31:0];
        if (r_acc > c_ACC_MAX) begin
            w_dot = 32'sh7FFF_FFFF;
        end else if (r_acc < c_ACC_MIN) begin
            w_dot = 32'sh8000_0000;
        end
    end

    assign w_y_rd        = r_y_buf[r_rd_idx];
    assign w_dy_rd       = r_dy_buf[r_rd_idx];
    assign w_diff        = $signed({w_dy_rd[31], w_dy_rd}) - $signed({w_dot[31], w_dot});
    assign w_prod_out    = $signed({{33{w_y_rd[31]}}, w_y_rd}) * $signed({{32{w_diff[32]}}, w_diff});
    assign w_prod_out_sh = w_prod_out >>> FRAC_BITS;

    always_comb begin
        w_dx = w_prod_out_sh[31:0];
        if (w_prod_out_sh > c_OUT_MAX) begin
            w_dx = 32'h7FFF_FFFF;
        end else if (w_prod_out_sh < c_OUT_MIN) begin
            w_dx = 32'h8000_0000;
        end
    end

    // Vector storage carries no reset; a reset simply abandons its contents.
    always_ff @(posedge clk) begin
        if (w_in_hs) begin
            r_y_buf[r_wr_idx]  <= y_in;
            r_dy_buf[r_wr_idx] <= dy_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_LOAD;
            r_wr_idx    <= '0;
            r_rd_idx    <= '0;
            r_acc       <= '0;
            valid_out   <= 1'b0;
            output_data <= '0;
            last_out    <= 1'b0;
        end else begin
            case (r_state)
                c_ST_LOAD: begin
                    if (w_in_hs) begin
                        r_acc <= r_acc + w_term;
                        if (r_wr_idx == c_LAST_IDX) begin
                            r_wr_idx <= '0;
                            r_state  <= c_ST_DRAIN;
                        end else begin
                            r_wr_idx <= r_wr_idx + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    if (w_out_hs && last_out) begin
                        valid_out <= 1'b0;
                        last_out  <= 1'b0;
                        r_rd_idx  <= '0;
                        r_acc     <= '0;
                        r_state   <= c_ST_LOAD;
                    end else if (w_out_load) begin
                        output_data <= w_dx;
                        valid_out   <= 1'b1;
                        last_out    <= (r_rd_idx == c_LAST_IDX);
                        r_rd_idx    <= (r_rd_idx == c_LAST_IDX) ? '0 : r_rd_idx + IDX_W'(1);
                    end else if (w_out_hs) begin
                        valid_out <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_softmax_backward.sv
`default_nettype none
// ============================================================================
// Module   : tb_softmax_backward
// Brief    : Directed self-checking bench for softmax_backward (VEC_LEN=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_softmax_backward;

    localparam int VL = 4;
    localparam int FB = 16;
    localparam longint c_LMAX = 64'sd2147483647;
    localparam longint c_LMIN = -64'sd2147483648;

    typedef logic [31:0] vec_t [VL];

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        valid_in = 1'b0;
    logic        ready_in;
    logic [31:0] y_in = '0;
    logic [31:0] dy_in = '0;
    logic        valid_out;
    logic        ready_out = 1'b1;
    logic [31:0] output_data;
    logic        last_out;

    always #5 clk = ~clk;

    softmax_backward #(.VEC_LEN(VL), .FRAC_BITS(FB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_in    (valid_in),
        .ready_in    (ready_in),
        .y_in        (y_in),
        .dy_in       (dy_in),
        .valid_out   (valid_out),
        .ready_out   (ready_out),
        .output_data (output_data),
        .last_out    (last_out)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          n_hs = 0;
    int          n_last = 0;
    logic [31:0] exp_d [$];
    logic        exp_l [$];
    logic [31:0] got_q [$];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_d = '0;
    logic        prev_l = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Reference arithmetic: exact rational math with floor rounding and clamps.
    function automatic longint floor_div(input longint a);
        longint s;
        s = longint'(1) << FB;
        if (a >= 0) return a / s;
        return -((-a + s - 1) / s);
    endfunction

    function automatic longint clamp32(input longint a);
        if (a > c_LMAX) return c_LMAX;
        if (a < c_LMIN) return c_LMIN;
        return a;
    endfunction

    task automatic model(input vec_t y, input vec_t dy);
        longint dot;
        longint d;
        dot = 0;
        for (int i = 0; i < VL; i++)
            dot += floor_div(longint'($signed(y[i])) * longint'($signed(dy[i])));
        dot = clamp32(dot);
        for (int i = 0; i < VL; i++) begin
            d = clamp32(floor_div(longint'($signed(y[i])) * (longint'($signed(dy[i])) - dot)));
            exp_d.push_back(d[31:0]);
            exp_l.push_back(i == VL - 1);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                check("hold_valid", {31'd0, valid_out}, 32'd1);
                check("hold_data", output_data, prev_d);
                check("hold_last", {31'd0, last_out}, {31'd0, prev_l});
            end
            if (valid_out && ready_out) begin
                if (exp_d.size() == 0) begin
                    fail_now("unexpected_output");
                end else begin
                    check("dx_model", output_data, exp_d.pop_front());
                    check("last_model", {31'd0, last_out}, {31'd0, exp_l.pop_front()});
                end
                got_q.push_back(output_data);
                n_hs++;
                if (last_out) n_last++;
            end
            prev_stall = valid_out && !ready_out;
            prev_d     = output_data;
            prev_l     = last_out;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic send_vec(input vec_t y, input vec_t dy, input bit stall);
        int tries;
        bit ph;
        bit hs;
        ph = 1'b0;
        model(y, dy);
        for (int i = 0; i < VL; i++) begin
            tries = 0;
            forever begin
                if (stall && ph) begin
                    valid_in = 1'b0;
                    y_in     = $urandom;
                    dy_in    = $urandom;
                end else begin
                    valid_in = 1'b1;
                    y_in     = y[i];
                    dy_in    = dy[i];
                end
                ph = ~ph;
                hs = valid_in && ready_in;
                @(posedge clk);
                #1;
                if (hs) break;
                tries++;
                if (tries > 60) begin
                    fail_now("input_timeout");
                    valid_in = 1'b0;
                    return;
                end
            end
        end
        valid_in = 1'b0;
        y_in     = '0;
        dy_in    = '0;
        check("ready_in_drop", {31'd0, ready_in}, 32'd0);
        check("no_early_valid", {31'd0, valid_out}, 32'd0);
        @(posedge clk);
        #1;
        check("first_valid", {31'd0, valid_out}, 32'd1);
    endtask

    task automatic wait_last(input int target, output int cyc);
        cyc = 0;
        while (n_last < target) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc > 200) begin
                fail_now("drain_timeout");
                return;
            end
        end
        check("ready_in_back", {31'd0, ready_in}, 32'd1);
    endtask

    task automatic check_lit(input vec_t e);
        for (int i = 0; i < VL; i++) begin
            if (got_q.size() == 0) fail_now("lit_missing");
            else check("dx_literal", got_q.pop_front(), e[i]);
        end
    endtask

    initial begin
        vec_t yb, dyb, ys, dys, y2, dy2, lit_basic, lit_sat, lit2;
        int cyc;
        int base;
        yb        = '{32'h0000_4000, 32'h0000_4000, 32'h0000_4000, 32'h0000_4000};
        dyb       = '{32'h0001_0000, 32'h0, 32'h0, 32'h0};
        ys        = '{32'h7FFF_0000, 32'h0, 32'h0, 32'h0};
        dys       = '{32'h0001_0000, 32'h0, 32'h0, 32'h0};
        y2        = '{32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 32'h0000_8000};
        dy2       = '{32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000};
        lit_basic = '{32'h0000_3000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000};
        lit_sat   = '{32'h8000_0000, 32'h0, 32'h0, 32'h0};
        lit2      = '{32'hFFFF_8000, 32'hFFFF_8000, 32'hFFFF_8000, 32'hFFFF_8000};

        #1 rst_n = 1'b0;
        #1;
        check("rst_valid_out", {31'd0, valid_out}, 32'd0);
        check("rst_data", output_data, 32'd0);
        check("rst_last", {31'd0, last_out}, 32'd0);
        check("rst_ready_in", {31'd0, ready_in}, 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // basic vector
        send_vec(yb, dyb, 1'b0);
        wait_last(1, cyc);
        check("basic_drain_cycles", cyc, 32'd4);
        check_lit(lit_basic);

        // saturation
        send_vec(ys, dys, 1'b0);
        wait_last(2, cyc);
        check_lit(lit_sat);

        // backpressure: first word held for 5 cycles
        ready_out = 1'b0;
        send_vec(yb, dyb, 1'b0);
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", {31'd0, valid_out}, 32'd1);
            check("bp_data", output_data, 32'h0000_3000);
            check("bp_last", {31'd0, last_out}, 32'd0);
            check("bp_ready_in", {31'd0, ready_in}, 32'd0);
            if (k < 4) begin
                @(posedge clk);
                #1;
            end
        end
        ready_out = 1'b1;
        wait_last(3, cyc);
        check("bp_drain_cycles", cyc, 32'd4);
        check_lit(lit_basic);

        // back-to-back: second vector waits on ready_in with valid_in held high
        send_vec(yb, dyb, 1'b0);
        send_vec(y2, dy2, 1'b0);
        wait_last(5, cyc);
        check_lit(lit_basic);
        check_lit(lit2);

        // reset in the middle of draining
        base = n_hs;
        send_vec(yb, dyb, 1'b0);
        cyc = 0;
        while (n_hs < base + 2 && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (n_hs < base + 2) fail_now("pre_reset_timeout");
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_valid_out", {31'd0, valid_out}, 32'd0);
        check("mid_rst_data", output_data, 32'd0);
        check("mid_rst_last", {31'd0, last_out}, 32'd0);
        check("mid_rst_ready_in", {31'd0, ready_in}, 32'd1);
        exp_d.delete();
        exp_l.delete();
        got_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        send_vec(yb, dyb, 1'b0);
        wait_last(6, cyc);
        check_lit(lit_basic);

        // input stall: valid_in toggles each cycle
        send_vec(yb, dyb, 1'b1);
        wait_last(7, cyc);
        check_lit(lit_basic);

        check("leftover_expected", exp_d.size(), 32'd0);
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
